// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode sequencer: requests one instruction word per PC value, decodes it
// for a single EXEC cycle into PC-unit strobes, and stops on HALT, illegal opcode or fetch timeout.
module fetch_decode_ctrl #(
    parameter int BITSIZE = 16,
    parameter int TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [BITSIZE-1:0] pc_in_i,
    output logic               imem_req_o,
    output logic [BITSIZE-1:0] imem_addr_o,
    input  logic               imem_ack_i,
    input  logic [15:0]        imem_data_i,
    output logic [7:0]         disp_o,
    output logic [3:0]         ra_o,
    output logic [3:0]         rw_o,
    output logic               jmp_o,
    output logic               branch_o,
    output logic               wren_o,
    output logic               clken_o,
    output logic               halted_o,
    output logic               fault_o,
    output logic [15:0]        retired_o
);

    typedef enum logic [1:0] {IDLE, REQ, EXEC, HALT} state_e;

    localparam int            CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO = CW'(TIMEOUT);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_BR   = 4'h1;
    localparam logic [3:0] OP_JR   = 4'h2;
    localparam logic [3:0] OP_JAL  = 4'h3;
    localparam logic [3:0] OP_LNK  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_e             state_q, state_d;
    logic [15:0]        ir_q;
    logic [CW-1:0]      wcnt_q;
    logic [CW-1:0]      wcnt_inc;
    logic [BITSIZE-1:0] addr_q;
    logic [15:0]        ret_q;
    logic               halted_q;
    logic               fault_q;
    logic [3:0]         opcode;
    logic               op_legal;
    logic               timeout_hit;

    assign opcode      = ir_q[15:12];
    assign op_legal    = (opcode <= OP_LNK);
    assign wcnt_inc    = wcnt_q + CW'(1);
    assign timeout_hit = (state_q == REQ) && !imem_ack_i && (wcnt_inc == TO);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (imem_ack_i) begin
                    state_d = EXEC;
                end else if (timeout_hit) begin
                    state_d = HALT;
                end
            end
            EXEC:    state_d = op_legal ? REQ : HALT;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: strobes exist only during the single EXEC cycle
    always_comb begin
        imem_req_o = (state_q == REQ);
        jmp_o      = 1'b0;
        branch_o   = 1'b0;
        wren_o     = 1'b0;
        clken_o    = 1'b0;
        if (state_q == EXEC) begin
            case (opcode)
                OP_NOP: clken_o = 1'b1;
                OP_BR: begin
                    clken_o  = 1'b1;
                    branch_o = 1'b1;
                end
                OP_JR: begin
                    clken_o = 1'b1;
                    jmp_o   = 1'b1;
                end
                OP_JAL: begin
                    clken_o = 1'b1;
                    jmp_o   = 1'b1;
                    wren_o  = 1'b1;
                end
                OP_LNK: begin
                    clken_o = 1'b1;
                    wren_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath: fetch address, IR, wait counter, retire counter, sticky flags
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            ir_q     <= '0;
            wcnt_q   <= '0;
            ret_q    <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            // Address is captured once on REQ entry so it stays stable while waiting
            if (state_d == REQ && state_q != REQ) begin
                addr_q <= pc_in_i;
            end
            if (state_q == REQ) begin
                if (imem_ack_i) begin
                    ir_q   <= imem_data_i;
                    wcnt_q <= '0;
                end else begin
                    wcnt_q <= wcnt_inc;
                end
            end
            if (clken_o) begin
                ret_q <= ret_q + 16'd1;
            end
            if (timeout_hit) begin
                halted_q <= 1'b1;
                fault_q  <= 1'b1;
            end
            if (state_q == EXEC && !op_legal) begin
                halted_q <= 1'b1;
                if (opcode != OP_HALT) begin
                    fault_q <= 1'b1;
                end
            end
        end
    end

    assign imem_addr_o = addr_q;
    assign disp_o      = ir_q[7:0];
    assign ra_o        = ir_q[7:4];
    assign rw_o        = ir_q[11:8];
    assign halted_o    = halted_q;
    assign fault_o     = fault_q;
    assign retired_o   = ret_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Scoreboard bench for fetch_decode_ctrl: directed fetches push expected EXEC
// responses; a negedge monitor pops and compares whenever strobes appear.
module tb_fetch_decode_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc_in;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [7:0]  disp;
    logic [3:0]  ra;
    logic [3:0]  rw;
    logic        jmp;
    logic        branch;
    logic        wren;
    logic        clken;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    typedef struct {
        logic        jmp;
        logic        br;
        logic        wren;
        logic [7:0]  disp;
        logic [3:0]  ra;
        logic [3:0]  rw;
        logic [15:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    logic [15:0] exp_addr;
    logic [15:0] exp_ret;
    logic        quiet;

    fetch_decode_ctrl #(.BITSIZE(16), .TIMEOUT(15)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pc_in_i     (pc_in),
        .imem_req_o  (imem_req),
        .imem_addr_o (imem_addr),
        .imem_ack_i  (imem_ack),
        .imem_data_i (imem_data),
        .disp_o      (disp),
        .ra_o        (ra),
        .rw_o        (rw),
        .jmp_o       (jmp),
        .branch_o    (branch),
        .wren_o      (wren),
        .clken_o     (clken),
        .halted_o    (halted),
        .fault_o     (fault),
        .retired_o   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every cycle showing a strobe must match the oldest expected EXEC
    always @(negedge clk) begin
        if (rst_n && (clken || jmp || branch || wren)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {clken, jmp, branch, wren}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("exec_strobes", {imem_req, clken, jmp, branch, wren},
                      {1'b0, 1'b1, mon_e.jmp, mon_e.br, mon_e.wren});
                check("exec_fields", {disp, ra, rw}, {mon_e.disp, mon_e.ra, mon_e.rw});
                check("exec_retired", retired, mon_e.ret);
            end
        end
    end

    // Called at a negedge; wait for REQ, optionally stall, ack, then act as PC unit during EXEC
    task automatic fetch(input logic [15:0] instr, input int waits, input logic [15:0] next_pc);
        int   n = 0;
        logic legal;
        exp_t e;
        legal = (instr[15:12] <= 4'h4);
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", imem_req, 1);
        check("fetch_addr", imem_addr, exp_addr);
        repeat (waits) @(negedge clk);
        check("addr_hold", imem_addr, exp_addr);
        check("req_quiet", {clken, jmp, branch, wren}, 0);
        if (legal) begin
            e.jmp  = (instr[15:12] == 4'h2) || (instr[15:12] == 4'h3);
            e.br   = (instr[15:12] == 4'h1);
            e.wren = (instr[15:12] == 4'h3) || (instr[15:12] == 4'h4);
            e.disp = instr[7:0];
            e.ra   = instr[7:4];
            e.rw   = instr[11:8];
            e.ret  = exp_ret;
            exp_q.push_back(e);
            exp_ret = exp_ret + 16'd1;
        end
        imem_ack  = 1'b1;
        imem_data = instr;
        @(negedge clk);
        // ack stays high with different data through EXEC; it must not reach IR
        imem_data = ~instr;
        pc_in     = next_pc;
        exp_addr  = next_pc;
        @(negedge clk);
        imem_ack = 1'b0;
        if (legal) check("ir_keep", {disp, rw}, {instr[7:0], instr[11:8]});
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_strobes", {clken, jmp, branch, wren}, 0);
        check("rst_retired", retired, 0);
        check("rst_flags", {halted, fault}, 0);
        check("rst_addr_ir", {imem_addr, disp, rw}, 0);
        exp_q.delete();
        exp_ret = 16'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("idle_req", imem_req, 0);
        exp_addr = pc_in;
        @(negedge clk);
        check("req_after_rel", imem_req, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        pc_in     = 16'h0010;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        exp_addr  = 16'h0000;
        exp_ret   = 16'd0;
        do_reset();

        // Zero-wait NOP stream: EXEC every other cycle, five retired
        for (int i = 0; i < 5; i++) fetch(16'h0000, 0, 16'h0011 + 16'(i));
        check("nop_retired", retired, 5);

        fetch(16'h10F3, 1, 16'h0008);
        fetch(16'h3460, 2, 16'h0246);
        fetch(16'h2050, 0, 16'h1005);
        fetch(16'h4A00, 0, 16'h1006);
        fetch(16'hF000, 1, 16'h1007);
        check("halt_flags", {halted, fault, imem_req}, 3'b100);
        check("halt_retired", retired, exp_ret);
        check("halt_retired_abs", retired, 9);
        quiet    = 1'b0;
        imem_ack = 1'b1;
        repeat (4) begin
            @(negedge clk);
            quiet |= clken | imem_req;
        end
        imem_ack = 1'b0;
        check("halt_quiet", {quiet, halted}, 2'b01);

        // Reset in the middle of a stalled REQ
        do_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Reset while EXEC strobes are live; the pending instruction is dropped
        imem_ack  = 1'b1;
        imem_data = 16'h10F3;
        @(posedge clk);
        #2;
        imem_ack = 1'b0;
        check("exec_br_live", {branch, clken}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rst_exec_strobes", {clken, jmp, branch, wren, imem_req}, 0);
        do_reset();

        // Illegal opcode after one good instruction
        fetch(16'h0000, 0, 16'h0020);
        fetch(16'h7000, 1, 16'h0021);
        check("illegal_flags", {halted, fault, imem_req}, 3'b110);
        check("illegal_retired", retired, 1);

        // Fetch timeout: 15 REQ cycles without ack
        pc_in = 16'h0300;
        do_reset();
        check("to_addr", imem_addr, 16'h0300);
        repeat (14) @(negedge clk);
        check("to_still_req", {imem_req, fault, halted}, 3'b100);
        @(negedge clk);
        check("to_fault", {imem_req, fault, halted}, 3'b011);
        quiet    = 1'b0;
        imem_ack = 1'b1;
        repeat (6) begin
            @(negedge clk);
            quiet |= clken | imem_req | jmp | branch | wren;
        end
        imem_ack = 1'b0;
        check("to_quiet", quiet, 0);

        check("sb_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
